r4booth_iter_mul: RTL and testbench

Iterative, parametrised Radix-4 Booth multiplier for the FP mantissa datapath. It accepts one operand pair per transaction over a valid/ready handshake and retires PARM_DPC Booth digits per clock into a registered accumulator. The final product is presented on a held valid/ready output. The block is the area-lean alternative to the combinational 13-row partial-product array plus compressor tree. Width and digits-per-cycle are parameters, and a run-time signed mode is provided.

---
 rtl/r4booth_iter_mul_if.sv | 26 ++
 rtl/r4booth_iter_mul.sv | 98 +++++++++
 tb/tb_r4booth_iter_mul.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/r4booth_iter_mul_if.sv
// Operand/product handshake bundle for the iterative radix-4 Booth multiplier.
// Signal names are relative to the multiplier: *_i are driven into it, *_o come out of it.
interface r4booth_iter_mul_if #(
  parameter int PARM_MANT = 23
);
  localparam int N = PARM_MANT + 1;

  logic           valid_i;
  logic           ready_o;
  logic [N-1:0]   mant_a_i;
  logic [N-1:0]   mant_b_i;
  logic           signed_i;
  logic           valid_o;
  logic           ready_i;
  logic [2*N-1:0] prod_o;

  modport slave (
    input  valid_i, mant_a_i, mant_b_i, signed_i, ready_i,
    output ready_o, valid_o, prod_o
  );

  modport master (
    output valid_i, mant_a_i, mant_b_i, signed_i, ready_i,
    input  ready_o, valid_o, prod_o
  );
endinterface

// File: rtl/r4booth_iter_mul.sv
// Iterative radix-4 Booth multiplier: retires PARM_DPC Booth digits per clock into
// a 2N-bit accumulator; product is held on a valid/ready output until taken.
module r4booth_iter_mul #(
  parameter int PARM_MANT = 23,
  parameter int PARM_DPC  = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  r4booth_iter_mul_if.slave      bus
);
  localparam int N     = PARM_MANT + 1;
  localparam int K     = N / 2 + 1;
  localparam int C     = (K + PARM_DPC - 1) / PARM_DPC;
  localparam int W     = 2 * N;
  localparam int BW    = N + 3;
  localparam int SH    = 2 * PARM_DPC;
  localparam int CNT_W = $clog2(C + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       acc_q;
  logic [W-1:0]       a_sh_q;
  logic [BW-1:0]      b_sh_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [W-1:0]       sum_d;
  logic               take;
  logic               last_cyc;
  logic               e_a;
  logic               e_b;

  // Radix-4 digit times the (already aligned) multiplicand, modulo 2^W.
  function automatic logic [W-1:0] booth_pp(input logic [2:0] sel, input logic [W-1:0] m);
    case (sel)
      3'b001, 3'b010: booth_pp = m;
      3'b011:         booth_pp = m << 1;
      3'b100:         booth_pp = -(m << 1);
      3'b101, 3'b110: booth_pp = -m;
      default:        booth_pp = '0;
    endcase
  endfunction

  assign take     = bus.valid_i && (state_q == IDLE);
  assign last_cyc = (cnt_q == CNT_W'(C - 1));
  assign e_a      = bus.signed_i & bus.mant_a_i[N-1];
  assign e_b      = bus.signed_i & bus.mant_b_i[N-1];

  // Multiplicand shifts left with the digits, so no barrel shifter is needed on the
  // accumulator; digits past K-1 read sign-fill bits of B and decode to zero.
  always_comb begin
    sum_d = acc_q;
    for (int d = 0; d < PARM_DPC; d++) begin
      sum_d = sum_d + booth_pp(b_sh_q[2*d +: 3], a_sh_q << (2 * d));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.valid_i) state_d = CALC;
      CALC:    if (last_cyc)    state_d = DONE;
      DONE:    if (bus.ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      cnt_q  <= '0;
    end else if (take) begin
      acc_q  <= '0;
      a_sh_q <= {{(W-N){e_a}}, bus.mant_a_i};
      b_sh_q <= {e_b, e_b, bus.mant_b_i, 1'b0};
      cnt_q  <= '0;
    end else if (state_q == CALC) begin
      acc_q  <= sum_d;
      a_sh_q <= a_sh_q << SH;
      b_sh_q <= {{SH{b_sh_q[BW-1]}}, b_sh_q[BW-1:SH]};
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.valid_o = (state_q == DONE);
  assign bus.prod_o  = acc_q;

endmodule

// File: tb/tb_r4booth_iter_mul.sv
// Bench for r4booth_iter_mul: one instance per digits-per-cycle setting, directed
// corner cases plus random operand pairs against a plain-arithmetic product model.
module tb_r4booth_iter_mul;
  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  r4booth_iter_mul_if #(.PARM_MANT(23)) bus1 ();
  r4booth_iter_mul_if #(.PARM_MANT(23)) bus2 ();

  r4booth_iter_mul #(.PARM_MANT(23), .PARM_DPC(1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));
  r4booth_iter_mul #(.PARM_MANT(23), .PARM_DPC(2)) dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] ref_mul(input logic [23:0] a, input logic [23:0] b, input logic s);
    logic signed [63:0] ea, eb, p;
    ea = s ? {{40{a[23]}}, a} : {40'd0, a};
    eb = s ? {{40{b[23]}}, b} : {40'd0, b};
    p  = ea * eb;
    return p[47:0];
  endfunction

  task automatic set_in(input int u, input logic v, input logic [23:0] a, input logic [23:0] b, input logic s);
    if (u == 0) begin
      bus1.valid_i = v; bus1.mant_a_i = a; bus1.mant_b_i = b; bus1.signed_i = s;
    end else begin
      bus2.valid_i = v; bus2.mant_a_i = a; bus2.mant_b_i = b; bus2.signed_i = s;
    end
  endtask

  task automatic set_rdy(input int u, input logic r);
    if (u == 0) bus1.ready_i = r; else bus2.ready_i = r;
  endtask

  function automatic logic get_vo(input int u);
    return (u == 0) ? bus1.valid_o : bus2.valid_o;
  endfunction

  function automatic logic get_ro(input int u);
    return (u == 0) ? bus1.ready_o : bus2.ready_o;
  endfunction

  function automatic logic [47:0] get_prod(input int u);
    return (u == 0) ? bus1.prod_o : bus2.prod_o;
  endfunction

  // Called #1 after a rising edge with the unit idle; returns once valid_o is seen
  // (or the cycle budget runs out) together with the edge count since acceptance.
  task automatic start_txn(input int u, input logic [23:0] a, input logic [23:0] b, input logic s,
                           output int lat, output logic [47:0] p);
    chk("ready_before_issue", 48'(get_ro(u)), 48'd1);
    set_in(u, 1'b1, a, b, s);
    @(posedge clk); #1;
    set_in(u, 1'b0, $urandom(), $urandom(), $urandom_range(1));
    lat = 0;
    while (!get_vo(u) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    p = get_prod(u);
  endtask

  task automatic finish_txn(input int u);
    set_rdy(u, 1'b1);
    @(posedge clk); #1;
    set_rdy(u, 1'b0);
    chk("ready_after_handshake", 48'(get_ro(u)), 48'd1);
    chk("valid_after_handshake", 48'(get_vo(u)), 48'd0);
  endtask

  task automatic directed(input int u, input string tag, input logic [23:0] a, input logic [23:0] b,
                          input logic s, input int exp_lat);
    int lat;
    logic [47:0] p;
    start_txn(u, a, b, s, lat, p);
    chk({tag, "_lat"}, 48'(lat), 48'(exp_lat));
    chk(tag, p, ref_mul(a, b, s));
    finish_txn(u);
  endtask

  function automatic logic [23:0] pick_op();
    case ($urandom_range(7))
      0: return 24'h000000;
      1: return 24'h800000;
      2: return 24'hFFFFFF;
      3: return 24'h7FFFFF;
      default: return 24'($urandom());
    endcase
  endfunction

  initial begin
    int lat;
    int seen;
    logic [47:0] p, hold;
    logic [23:0] ra, rb;
    logic rs;

    rst_n = 1'b0;
    set_in(0, 1'b0, '0, '0, 1'b0);
    set_in(1, 1'b0, '0, '0, 1'b0);
    set_rdy(0, 1'b0);
    set_rdy(1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", 48'(get_ro(0)), 48'd1);
    chk("reset_valid", 48'(get_vo(0)), 48'd0);
    chk("reset_prod", get_prod(0), 48'd0);

    // Directed corners
    directed(0, "unsigned_max", 24'hFFFFFF, 24'hFFFFFF, 1'b0, 13);
    chk("unsigned_max_const", ref_mul(24'hFFFFFF, 24'hFFFFFF, 1'b0), 48'hFFFFFE000001);
    directed(0, "signed_neg1x3", 24'hFFFFFF, 24'h000003, 1'b1, 13);
    directed(0, "signed_extreme", 24'h800000, 24'h800000, 1'b1, 13);
    directed(1, "dpc2_unsigned", 24'h800000, 24'h000002, 1'b0, 7);
    directed(1, "dpc2_signed_ext", 24'h800000, 24'h800000, 1'b1, 7);
    directed(1, "dpc2_signed_neg", 24'hFFFFFF, 24'h000003, 1'b1, 7);

    // Backpressure in DONE with noisy inputs
    start_txn(0, 24'hFFFFFF, 24'hFFFFFF, 1'b0, lat, hold);
    chk("bp_prod", hold, 48'hFFFFFE000001);
    for (int i = 0; i < 5; i++) begin
      set_in(0, i[0] ? 1'b0 : 1'b1, 24'($urandom()), 24'($urandom()), 1'($urandom_range(1)));
      @(posedge clk); #1;
      chk("bp_prod_stable", get_prod(0), hold);
      chk("bp_ready_low", 48'(get_ro(0)), 48'd0);
      chk("bp_valid_held", 48'(get_vo(0)), 48'd1);
    end
    set_in(0, 1'b0, '0, '0, 1'b0);
    finish_txn(0);

    // Asynchronous reset while holding a result in DONE
    start_txn(0, 24'h000007, 24'h000009, 1'b0, lat, p);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 48'(get_vo(0)), 48'd0);
    chk("async_rst_ready", 48'(get_ro(0)), 48'd1);
    chk("async_rst_prod", get_prod(0), 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset five edges into CALC aborts the transaction
    set_in(0, 1'b1, 24'h123456, 24'h654321, 1'b0);
    @(posedge clk); #1;
    set_in(0, 1'b0, '0, '0, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midop_rst_ready", 48'(get_ro(0)), 48'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (get_vo(0)) seen++;
    end
    chk("midop_no_valid", 48'(seen), 48'd0);
    directed(0, "after_abort_3x5", 24'd3, 24'd5, 1'b0, 13);
    chk("after_abort_const", ref_mul(24'd3, 24'd5, 1'b0), 48'd15);

    // Random pairs, both modes, both digit rates
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = pick_op();
        rb = pick_op();
        rs = 1'($urandom_range(1));
        start_txn(u, ra, rb, rs, lat, p);
        chk(u == 0 ? "rand_dpc1" : "rand_dpc2", p, ref_mul(ra, rb, rs));
        chk("rand_lat", 48'(lat), u == 0 ? 48'd13 : 48'd7);
        finish_txn(u);
        if (n_fail > 20) break;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
